// File: rtl/spi_sd_responder_pkg.sv
// Shared types and constants for the SPI-mode SD card command responder:
// FSM states, command indices, R1 bit positions and frame/response sizes.
package spi_sd_responder_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CMD  = 2'd1,
        ST_NCR  = 2'd2,
        ST_RESP = 2'd3
    } state_t;

    localparam logic [5:0] CMD_GO_IDLE_STATE   = 6'd0;
    localparam logic [5:0] CMD_SEND_IF_COND    = 6'd8;
    localparam logic [5:0] CMD_SET_BLOCKLEN    = 6'd16;
    localparam logic [5:0] CMD_SD_SEND_OP_COND = 6'd41;
    localparam logic [5:0] CMD_APP_CMD         = 6'd55;
    localparam logic [5:0] CMD_READ_OCR        = 6'd58;

    localparam int unsigned R1_IDLE      = 0;
    localparam int unsigned R1_ILLEGAL   = 2;
    localparam int unsigned R1_CRC_ERR   = 3;
    localparam int unsigned R1_PARAM_ERR = 6;

    localparam int unsigned FRAME_BITS      = 48;
    localparam int unsigned CRC_COVER_BITS  = 40;
    localparam int unsigned NCR_BITS        = 8;
    localparam int unsigned RESP_BYTES_R1   = 1;
    localparam int unsigned RESP_BYTES_R3R7 = 5;

endpackage

// File: rtl/spi_sd_responder_crc7.sv
// Serial CRC7 (x^7 + x^3 + 1) accumulator, MSB-first data, synchronous clear.
// Instantiated by spi_sd_responder only when SPI_RESP_CRC_EN is defined.
module spi_crc7 (
    input  logic       clk,
    input  logic       rst,
    input  logic       i_clr,
    input  logic       i_en,
    input  logic       i_bit,
    output logic [6:0] o_crc
);

    logic [6:0] r_crc;
    logic [6:0] w_base;
    logic [6:0] w_next;
    logic       w_fb;

    // Clear and shift may coincide: the first bit of a frame starts from zero.
    always_comb begin
        w_base = i_clr ? 7'd0 : r_crc;
        w_fb   = w_base[6] ^ i_bit;
        w_next = w_base;
        if (i_en) begin
            w_next = {w_base[5:3], w_base[2] ^ w_fb, w_base[1:0], w_fb};
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_crc <= 7'd0;
        end else begin
            r_crc <= w_next;
        end
    end

    assign o_crc = r_crc;

endmodule

// File: rtl/spi_sd_responder.sv
// SPI-mode SD card command responder: receives 48-bit command frames and
// answers with R1/R3/R7. Define SPI_RESP_CRC_EN to enable CRC7 checking.
module spi_sd_responder
    import spi_sd_responder_pkg::*;
#(
    parameter logic [31:0] OCR_VALUE  = 32'hC0FF8000,
    parameter int unsigned INIT_POLLS = 3
) (
    input  logic        spi_clk_i,
    input  logic        spi_rst_i,
    input  logic        SCK_SPI,
    input  logic        SS,
    input  logic        MOSI,
    output logic        MISO,
    output logic [5:0]  spi_cmd_o,
    output logic [31:0] spi_arg_o,
    output logic        spi_cmdvalid_o,
    output logic        spi_ready_o
);

    localparam int unsigned PW        = (INIT_POLLS > 0) ? $clog2(INIT_POLLS + 1) : 1;
    localparam logic [5:0]  LAST_BIT  = 6'(FRAME_BITS - 1);
    localparam logic [5:0]  TX_LEN_R1 = 6'(NCR_BITS + 8 * RESP_BYTES_R1);
    localparam logic [5:0]  TX_LEN_R7 = 6'(NCR_BITS + 8 * RESP_BYTES_R3R7);

    logic [1:0]  r_sck_sync;
    logic [1:0]  r_ss_sync;
    logic [1:0]  r_mosi_sync;
    logic        r_sck_prev;
    logic        w_sck_rise;
    logic        w_sck_fall;
    logic        w_ss_hi;
    logic        w_mosi;

    state_t      r_state;
    state_t      w_state_next;
    logic        w_rx_shift;
    logic        w_frame_done;
    logic        w_tx_shift;
    logic        w_tx_done;

    logic [46:0] r_rx;
    logic [5:0]  r_bit_cnt;
    logic [47:0] r_tx;
    logic [5:0]  r_tx_cnt;
    logic [5:0]  r_tx_len;
    logic        r_miso;

    logic          r_ready;
    logic          r_app;
    logic [PW-1:0] r_polls;
    logic [5:0]    r_cmd;
    logic [31:0]   r_arg;
    logic          r_cmdvalid;

    logic          w_valid;
    logic          w_crc_ok;
    logic [5:0]    w_idx;
    logic [31:0]   w_arg;
    logic          w_exec;
    logic [7:0]    w_r1;
    logic          w_long;
    logic [31:0]   w_data;
    logic          w_ready_nx;
    logic          w_app_nx;
    logic [PW-1:0] w_polls_nx;

    // Input synchronizers, reset to the bus idle levels
    always_ff @(posedge spi_clk_i or posedge spi_rst_i) begin
        if (spi_rst_i) begin
            r_sck_sync  <= 2'b00;
            r_ss_sync   <= 2'b11;
            r_mosi_sync <= 2'b11;
            r_sck_prev  <= 1'b0;
        end else begin
            r_sck_sync  <= {r_sck_sync[0], SCK_SPI};
            r_ss_sync   <= {r_ss_sync[0], SS};
            r_mosi_sync <= {r_mosi_sync[0], MOSI};
            r_sck_prev  <= r_sck_sync[1];
        end
    end

    assign w_sck_rise = r_sck_sync[1] & ~r_sck_prev;
    assign w_sck_fall = ~r_sck_sync[1] & r_sck_prev;
    assign w_ss_hi    = r_ss_sync[1];
    assign w_mosi     = r_mosi_sync[1];

    always_ff @(posedge spi_clk_i or posedge spi_rst_i) begin
        if (spi_rst_i) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        if (w_ss_hi) begin
            w_state_next = ST_IDLE;
        end else begin
            case (r_state)
                ST_IDLE: if (w_sck_rise && !w_mosi)                  w_state_next = ST_CMD;
                ST_CMD:  if (w_sck_rise && r_bit_cnt == LAST_BIT)    w_state_next = ST_NCR;
                ST_NCR:  if (w_sck_fall && r_tx_cnt == 6'(NCR_BITS)) w_state_next = ST_RESP;
                ST_RESP: if (w_sck_fall && r_tx_cnt == r_tx_len)     w_state_next = ST_IDLE;
                default: w_state_next = ST_IDLE;
            endcase
        end
    end

    // Datapath strobes; MOSI is only looked at in IDLE and CMD
    always_comb begin
        w_rx_shift   = 1'b0;
        w_frame_done = 1'b0;
        w_tx_shift   = 1'b0;
        w_tx_done    = 1'b0;
        if (!w_ss_hi) begin
            case (r_state)
                ST_IDLE: w_rx_shift = w_sck_rise && !w_mosi;
                ST_CMD: begin
                    w_rx_shift   = w_sck_rise;
                    w_frame_done = w_sck_rise && (r_bit_cnt == LAST_BIT);
                end
                ST_NCR:  w_tx_shift = w_sck_fall;
                ST_RESP: begin
                    w_tx_done  = w_sck_fall && (r_tx_cnt == r_tx_len);
                    w_tx_shift = w_sck_fall && (r_tx_cnt != r_tx_len);
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge spi_clk_i or posedge spi_rst_i) begin
        if (spi_rst_i) begin
            r_rx      <= '0;
            r_bit_cnt <= 6'd0;
        end else if (w_ss_hi) begin
            r_bit_cnt <= 6'd0;
        end else if (w_rx_shift) begin
            r_rx      <= {r_rx[45:0], w_mosi};
            r_bit_cnt <= w_frame_done ? 6'd0 : r_bit_cnt + 6'd1;
        end
    end

    // Frame fields; bit 0 of the frame is the MOSI bit sampled this cycle
    assign w_valid = (r_rx[46:45] == 2'b01) && w_mosi;
    assign w_idx   = r_rx[44:39];
    assign w_arg   = r_rx[38:7];

`ifdef SPI_RESP_CRC_EN
    logic [6:0] w_crc;
    logic       w_crc_en;

    assign w_crc_en = w_rx_shift && (r_bit_cnt < 6'(CRC_COVER_BITS));

    spi_crc7 u_crc7 (
        .clk   (spi_clk_i),
        .rst   (spi_rst_i),
        .i_clr (r_state == ST_IDLE),
        .i_en  (w_crc_en),
        .i_bit (w_mosi),
        .o_crc (w_crc)
    );

    assign w_crc_ok = (w_crc == r_rx[6:0]);
`else
    assign w_crc_ok = 1'b1;
`endif

    // Command decode; evaluated only when w_frame_done is high
    always_comb begin
        w_ready_nx = r_ready;
        w_app_nx   = r_app;
        w_polls_nx = r_polls;
        w_exec     = 1'b0;
        w_r1       = 8'h00;
        w_long     = 1'b0;
        w_data     = 32'h0;
        if (!w_valid) begin
            w_app_nx             = 1'b0;
            w_r1[R1_PARAM_ERR]   = 1'b1;
            w_r1[R1_IDLE]        = ~r_ready;
        end else if (!w_crc_ok) begin
            w_r1[R1_CRC_ERR]     = 1'b1;
            w_r1[R1_IDLE]        = ~r_ready;
        end else begin
            w_exec   = 1'b1;
            w_app_nx = 1'b0;
            case (w_idx)
                CMD_GO_IDLE_STATE: begin
                    w_ready_nx = 1'b0;
                    w_polls_nx = '0;
                end
                CMD_SEND_IF_COND: begin
                    w_long = 1'b1;
                    w_data = {20'h0, w_arg[11:0]};
                end
                CMD_APP_CMD: w_app_nx = 1'b1;
                CMD_SD_SEND_OP_COND: begin
                    if (!r_app) begin
                        w_r1[R1_ILLEGAL] = 1'b1;
                    end else if (r_polls < PW'(INIT_POLLS)) begin
                        w_polls_nx = r_polls + PW'(1);
                    end else begin
                        w_ready_nx = 1'b1;
                    end
                end
                CMD_READ_OCR: begin
                    w_long = 1'b1;
                    w_data = OCR_VALUE;
                end
                CMD_SET_BLOCKLEN: ;
                default: w_r1[R1_ILLEGAL] = 1'b1;
            endcase
            w_r1[R1_IDLE] = ~w_ready_nx;
        end
    end

    // Response shifter: NCR 0xFF byte, R1, optional 32-bit payload
    always_ff @(posedge spi_clk_i or posedge spi_rst_i) begin
        if (spi_rst_i) begin
            r_tx     <= '1;
            r_tx_cnt <= 6'd0;
            r_tx_len <= 6'd0;
            r_miso   <= 1'b1;
        end else if (w_ss_hi) begin
            r_tx_cnt <= 6'd0;
            r_miso   <= 1'b1;
        end else if (w_frame_done) begin
            r_tx     <= {8'hFF, w_r1, (w_long ? w_data : 32'hFFFF_FFFF)};
            r_tx_cnt <= 6'd0;
            r_tx_len <= w_long ? TX_LEN_R7 : TX_LEN_R1;
        end else if (w_tx_shift) begin
            r_miso   <= r_tx[47];
            r_tx     <= {r_tx[46:0], 1'b1};
            r_tx_cnt <= r_tx_cnt + 6'd1;
        end else if (w_tx_done) begin
            r_miso   <= 1'b1;
        end
    end

    // Card state and command report
    always_ff @(posedge spi_clk_i or posedge spi_rst_i) begin
        if (spi_rst_i) begin
            r_ready    <= 1'b0;
            r_app      <= 1'b0;
            r_polls    <= '0;
            r_cmd      <= 6'd0;
            r_arg      <= 32'h0;
            r_cmdvalid <= 1'b0;
        end else begin
            r_cmdvalid <= w_frame_done && w_exec;
            if (w_frame_done) begin
                r_ready <= w_ready_nx;
                r_app   <= w_app_nx;
                r_polls <= w_polls_nx;
                if (w_exec) begin
                    r_cmd <= w_idx;
                    r_arg <= w_arg;
                end
            end
        end
    end

    assign MISO           = r_miso;
    assign spi_cmd_o      = r_cmd;
    assign spi_arg_o      = r_arg;
    assign spi_cmdvalid_o = r_cmdvalid;
    assign spi_ready_o    = r_ready;

endmodule

// File: tb/tb_spi_sd_responder.sv
// Directed bench for spi_sd_responder: bit-banged SPI mode 0 initiator with
// hand-computed responses for the SD init sequence, errors, abort and reset.
module tb_spi_sd_responder;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        sck = 1'b0;
    logic        ss  = 1'b1;
    logic        mosi = 1'b1;
    logic        miso;
    logic [5:0]  cmd;
    logic [31:0] arg;
    logic        cmdvalid;
    logic        ready;

    int checks   = 0;
    int failures = 0;
    int pulses   = 0;

    logic [7:0] rb [6];

    spi_sd_responder dut (
        .spi_clk_i      (clk),
        .spi_rst_i      (rst),
        .SCK_SPI        (sck),
        .SS             (ss),
        .MOSI           (mosi),
        .MISO           (miso),
        .spi_cmd_o      (cmd),
        .spi_arg_o      (arg),
        .spi_cmdvalid_o (cmdvalid),
        .spi_ready_o    (ready)
    );

    always #5 clk = ~clk;

    always @(posedge clk) if (cmdvalid === 1'b1) pulses <= pulses + 1;

    task automatic check(input string tag, input logic [47:0] obs, input logic [47:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic spi_bit(input logic b, output logic m);
        mosi = b;
        repeat (6) @(negedge clk);
        m = miso;
        sck = 1'b1;
        repeat (8) @(negedge clk);
        sck = 1'b0;
    endtask

    task automatic spi_byte(input logic [7:0] tx, output logic [7:0] rx);
        logic m;
        for (int b = 7; b >= 0; b--) begin
            spi_bit(tx[b], m);
            rx[b] = m;
        end
    endtask

    task automatic send_bits(input logic [47:0] f, input int n);
        logic m;
        for (int i = 0; i < n; i++) spi_bit(f[47-i], m);
        mosi = 1'b1;
    endtask

    // Full transaction: 6 command bytes, then nresp bytes read (NCR first)
    task automatic xfer(input logic [47:0] f, input int nresp);
        logic [7:0] d;
        ss = 1'b0;
        repeat (4) @(negedge clk);
        for (int i = 0; i < 6; i++) spi_byte(f[47-8*i -: 8], d);
        for (int i = 0; i < nresp; i++) begin
            spi_byte(8'hFF, d);
            rb[i] = d;
        end
        mosi = 1'b1;
        repeat (4) @(negedge clk);
        ss = 1'b1;
        repeat (8) @(negedge clk);
    endtask

    localparam logic [47:0] F_CMD0     = 48'h40_0000_0000_95;
    localparam logic [47:0] F_CMD8     = 48'h48_0000_01AA_87;
    localparam logic [47:0] F_CMD17    = 48'h51_0000_0000_55;
    localparam logic [47:0] F_BADEND   = 48'h40_0000_0000_94;
    localparam logic [47:0] F_CMD55    = 48'h77_0000_0000_65;
    localparam logic [47:0] F_ACMD41   = 48'h69_4000_0000_77;
    localparam logic [47:0] F_CMD58    = 48'h7A_0000_0000_FD;
    localparam logic [47:0] F_CMD0_BAD = 48'h40_0000_0000_01;

    initial begin
        int p0;
        logic [7:0] exp_acmd [4];
        exp_acmd = '{8'h01, 8'h01, 8'h01, 8'h00};

        // Reset state
        repeat (3) @(negedge clk);
        check("rst_miso", 48'(miso), 48'h1);
        check("rst_cmd", 48'(cmd), 48'h0);
        check("rst_arg", 48'(arg), 48'h0);
        check("rst_valid", 48'(cmdvalid), 48'h0);
        check("rst_ready", 48'(ready), 48'h0);
        rst = 1'b0;
        repeat (4) @(negedge clk);

        // CMD0
        p0 = pulses;
        xfer(F_CMD0, 2);
        check("cmd0_ncr", 48'(rb[0]), 48'hFF);
        check("cmd0_r1", 48'(rb[1]), 48'h01);
        check("cmd0_pulse", 48'(pulses - p0), 48'd1);
        check("cmd0_idx", 48'(cmd), 48'd0);
        check("cmd0_arg", 48'(arg), 48'h0);

        // CMD8 -> R7
        p0 = pulses;
        xfer(F_CMD8, 6);
        check("cmd8_ncr", 48'(rb[0]), 48'hFF);
        check("cmd8_resp", {rb[1], rb[2], rb[3], rb[4], rb[5]}, 48'h01_0000_01AA);
        check("cmd8_pulse", 48'(pulses - p0), 48'd1);
        check("cmd8_idx", 48'(cmd), 48'd8);
        check("cmd8_arg", 48'(arg), 48'h1AA);

        // Illegal command
        p0 = pulses;
        xfer(F_CMD17, 2);
        check("cmd17_r1", 48'(rb[1]), 48'h05);
        check("cmd17_pulse", 48'(pulses - p0), 48'd1);
        check("cmd17_idx", 48'(cmd), 48'd17);

        // End bit 0 -> parameter error, no pulse, outputs untouched
        p0 = pulses;
        xfer(F_BADEND, 2);
        check("badend_r1", 48'(rb[1]), 48'h41);
        check("badend_pulse", 48'(pulses - p0), 48'd0);
        check("badend_idx", 48'(cmd), 48'd17);

        // ACMD41 init polling
        for (int i = 0; i < 4; i++) begin
            xfer(F_CMD55, 2);
            check("cmd55_r1", 48'(rb[1]), 48'h01);
            xfer(F_ACMD41, 2);
            check("acmd41_r1", 48'(rb[1]), 48'(exp_acmd[i]));
            check("acmd41_ready", 48'(ready), (i == 3) ? 48'h1 : 48'h0);
        end

        // CMD58 -> R3 with OCR
        xfer(F_CMD58, 6);
        check("cmd58_resp", {rb[1], rb[2], rb[3], rb[4], rb[5]}, 48'h00_C0FF_8000);
        check("cmd58_idx", 48'(cmd), 48'd58);

        // SS abort after 20 bits of CMD8
        p0 = pulses;
        ss = 1'b0;
        repeat (4) @(negedge clk);
        send_bits(F_CMD8, 20);
        ss = 1'b1;
        repeat (3) @(negedge clk);
        check("abort_miso", 48'(miso), 48'h1);
        repeat (20) @(negedge clk);
        check("abort_pulse", 48'(pulses - p0), 48'd0);
        check("abort_ready", 48'(ready), 48'h1);
        check("abort_idx", 48'(cmd), 48'd58);

        // CMD0 after abort re-enters idle
        p0 = pulses;
        xfer(F_CMD0, 2);
        check("post_abort_ncr", 48'(rb[0]), 48'hFF);
        check("post_abort_r1", 48'(rb[1]), 48'h01);
        check("post_abort_pulse", 48'(pulses - p0), 48'd1);
        check("post_abort_ready", 48'(ready), 48'h0);

        // CMD0 with a zero CRC field
        p0 = pulses;
        xfer(F_CMD0_BAD, 2);
`ifdef SPI_RESP_CRC_EN
        check("crc0_r1", 48'(rb[1]), 48'h09);
        check("crc0_pulse", 48'(pulses - p0), 48'd0);
`else
        check("crc0_r1", 48'(rb[1]), 48'h01);
        check("crc0_pulse", 48'(pulses - p0), 48'd1);
`endif

        // Reset in the middle of a frame
        xfer(F_CMD8, 6);
        check("pre_rst_arg", 48'(arg), 48'h1AA);
        ss = 1'b0;
        repeat (4) @(negedge clk);
        send_bits(F_CMD17, 20);
        #2 rst = 1'b1;
        #1;
        check("midrst_miso", 48'(miso), 48'h1);
        check("midrst_arg", 48'(arg), 48'h0);
        check("midrst_cmd", 48'(cmd), 48'h0);
        check("midrst_ready", 48'(ready), 48'h0);
        ss = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        repeat (4) @(negedge clk);
        p0 = pulses;
        xfer(F_CMD0, 2);
        check("post_rst_ncr", 48'(rb[0]), 48'hFF);
        check("post_rst_r1", 48'(rb[1]), 48'h01);
        check("post_rst_pulse", 48'(pulses - p0), 48'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
